// File: rtl/altavoz_pkg.sv
// Shared audio constants and types for the I2S capture/playback blocks.
// Sample width and slot geometry are common to both directions.
package altavoz_pkg;

  localparam int DATA_W     = 18;
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [BIT_W-1:0]  bit_idx_t;

  localparam bit_idx_t LAST_BIT  = bit_idx_t'(FRAME_BITS - 1);
  localparam bit_idx_t WS_SET    = bit_idx_t'(SLOT_W - 1);
  localparam bit_idx_t SLOT_BITS = bit_idx_t'(SLOT_W);
  localparam bit_idx_t DATA_BITS = bit_idx_t'(DATA_W);

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock generator: divides clk by 2*CLK_DIV and flags the cycle before
// each bclk edge with one-cycle rise_tk / fall_tk strobes.
module bclk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bclk,
  output logic rise_tk,
  output logic fall_tk
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic             tick;

  assign tick    = enable && (div_cnt == CNT_W'(CLK_DIV - 1));
  assign rise_tk = tick && !bclk;
  assign fall_tk = tick && bclk;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/altavoz.sv
// Playback-side I2S transmitter: one held sample is duplicated into the left
// and right slots of each 64-bit frame, MSB first, with ws leading by one bit.
module altavoz
  import altavoz_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] d_in,
  input  logic              valid,
  output logic              ready,
  output logic              d_out,
  output logic              ws,
  output logic              bclk,
  output logic              underrun
);

  logic     rise_tk, fall_tk;
  sample_t  hold_q, frame_q, frame_src, frame_shift;
  logic     full_q, frame_start, accept, d_nxt;
  bit_idx_t bit_cnt, bit_nxt, slot_bit;

  bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .bclk    (bclk),
    .rise_tk (rise_tk),
    .fall_tk (fall_tk)
  );

  assign ready = !full_q;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    frame_start = fall_tk && (bit_cnt == LAST_BIT);
    accept      = valid && !full_q;
    bit_nxt     = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    slot_bit    = (bit_nxt >= SLOT_BITS) ? bit_nxt - SLOT_BITS : bit_nxt;
    frame_src   = frame_q;
    if (frame_start) begin
      frame_src = full_q ? hold_q : '0;
    end
    frame_shift = frame_src << slot_bit;
    d_nxt       = (slot_bit < DATA_BITS) && frame_shift[DATA_W-1];
  end

  // The holding register is ordinary control state, so it is cleared too:
  // an empty/zeroed holder is what the handshake must present after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q   <= '0;
      full_q   <= 1'b0;
      frame_q  <= '0;
      bit_cnt  <= LAST_BIT;
      ws       <= 1'b0;
      d_out    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start && !full_q;

      if (accept) begin
        hold_q <= d_in;
        full_q <= 1'b1;
      end else if (frame_start) begin
        full_q <= 1'b0;
      end

      if (frame_start) begin
        frame_q <= frame_src;
      end

      // Parking bit_cnt on the last bit makes the next fall_tk a frame start.
      if (!enable) begin
        bit_cnt <= LAST_BIT;
        ws      <= 1'b0;
        d_out   <= 1'b0;
      end else if (fall_tk) begin
        bit_cnt <= bit_nxt;
        d_out   <= d_nxt;
        if (bit_nxt == WS_SET) begin
          ws <= 1'b1;
        end else if (bit_nxt == LAST_BIT) begin
          ws <= 1'b0;
        end
      end
    end
  end

  a_strobes_exclusive : assert property (
    @(posedge clk) disable iff (!reset) !(rise_tk && fall_tk)
  );

endmodule

// File: tb/tb_altavoz.sv
// Self-checking bench for altavoz: a time-based frame model checked every
// cycle, plus directed scenarios with hand-computed frame contents.
module tb_altavoz;

  localparam int CD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [17:0] d_in;
  logic        valid;
  logic        ready, d_out, ws, bclk, underrun;

  int checks = 0;
  int errors = 0;

  altavoz #(.CLK_DIV(CD)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .enable   (en),
    .d_in     (d_in),
    .valid    (valid),
    .ready    (ready),
    .d_out    (d_out),
    .ws       (ws),
    .bclk     (bclk),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: t counts enabled clk edges; every 2*CD edges is a bit, 64 bits a frame.
  int          t;
  logic        m_full;
  logic [17:0] m_hold, m_cur;
  logic        e_bclk, e_ws, e_dout, e_und, e_ready;

  always @(posedge clk) begin : model
    logic        fb;
    int          bitp, k;
    logic [17:0] tmp;
    if (!rst_n) begin
      t = 0; m_full = 1'b0; m_hold = '0; m_cur = '0; e_und = 1'b0;
    end else begin
      fb = m_full;
      e_und = 1'b0;
      if (!en) begin
        t = 0;
      end else begin
        t++;
        if ((t % (2 * CD)) == 0 && ((t / (2 * CD) - 1) % 64) == 0) begin
          if (fb) begin
            m_cur = m_hold; m_full = 1'b0;
          end else begin
            m_cur = '0; e_und = 1'b1;
          end
        end
      end
      if (valid && !fb) begin
        m_hold = d_in; m_full = 1'b1;
      end
    end
    e_bclk = (rst_n && en) ? (((t / CD) % 2) == 1) : 1'b0;
    e_ws = 1'b0;
    e_dout = 1'b0;
    if (rst_n && en && t >= 2 * CD) begin
      bitp = (t / (2 * CD) - 1) % 64;
      k = bitp % 32;
      e_ws = (bitp >= 31 && bitp < 63);
      if (k < 18) begin
        tmp = m_cur << k;
        e_dout = tmp[17];
      end
    end
    e_ready = !m_full;
    #1;
    if (rst_n) begin
      check("bclk", 64'(bclk), 64'(e_bclk));
      check("ws", 64'(ws), 64'(e_ws));
      check("d_out", 64'(d_out), 64'(e_dout));
      check("underrun", 64'(underrun), 64'(e_und));
      check("ready", 64'(ready), 64'(e_ready));
    end
  end

  // Receiver-side view: sample on bclk rising, collect left words after ws falls.
  logic [63:0] rx_sr = '0, rx_wsr = '0;
  logic        prev_ws = 1'b0;
  int          rx_cnt = -1;
  logic [17:0] rx_words[$];

  always @(posedge bclk) begin
    rx_sr  = {rx_sr[62:0], d_out};
    rx_wsr = {rx_wsr[62:0], ws};
    if (prev_ws && !ws) rx_cnt = 0;
    else if (rx_cnt >= 0) rx_cnt++;
    if (rx_cnt == 18) rx_words.push_back(rx_sr[17:0]);
    prev_ws = ws;
  end

  int   und_cnt = 0, rdy_rise = 0;
  logic prev_rdy = 1'b1;

  always @(posedge clk) begin
    #1;
    if (underrun === 1'b1) und_cnt++;
    if (ready === 1'b1 && !prev_rdy) rdy_rise++;
    prev_rdy = ready;
  end

  task automatic wait_ready(input logic lvl, input string name);
    int n = 0;
    while (ready !== lvl && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(ready), 64'(lvl));
  endtask

  initial begin
    int rr0;
    rst_n = 1'b0; en = 1'b0; valid = 1'b0; d_in = '0;
    cyc(3);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_dout", 64'(d_out), 64'd0);
    check("rst_bclk", 64'(bclk), 64'd0);
    rst_n = 1'b1;
    cyc(2);

    // Single sample queued before the first frame.
    d_in = 18'h2A5A5; valid = 1'b1;
    cyc(1);
    valid = 1'b0;
    check("single_ready_low", 64'(ready), 64'd0);
    en = 1'b1;
    cyc(3);
    check("single_pre_dout", 64'(d_out), 64'd0);
    cyc(257);
    check("single_frame", rx_sr, {18'h2A5A5, 14'b0, 18'h2A5A5, 14'b0});
    check("single_ws", rx_wsr, {31'b0, 32'hFFFF_FFFF, 1'b0});
    check("und_after_first", 64'(und_cnt), 64'd1);

    // Underrun: nothing offered for two more frames.
    cyc(512);
    check("und_two_frames", 64'(und_cnt), 64'd3);
    check("und_frame_zero", rx_sr, 64'd0);

    // Streaming 1, 2, 3 with valid held high.
    rx_words.delete();
    rr0 = rdy_rise;
    for (int s = 1; s <= 3; s++) begin
      d_in = 18'(s); valid = 1'b1;
      wait_ready(1'b1, "stream_ready_up");
      @(negedge clk);
      wait_ready(1'b0, "stream_accept");
    end
    valid = 1'b0;
    cyc(420);
    check("stream_nwords", 64'(rx_words.size()), 64'd4);
    if (rx_words.size() == 4) begin
      check("stream_w0", 64'(rx_words[0]), 64'd0);
      check("stream_w1", 64'(rx_words[1]), 64'd1);
      check("stream_w2", 64'(rx_words[2]), 64'd2);
      check("stream_w3", 64'(rx_words[3]), 64'd3);
    end
    check("stream_no_und", 64'(und_cnt), 64'd3);
    check("stream_rdy_rises", 64'(rdy_rise - rr0), 64'd3);

    // Enable drop at left-slot bit 5 with a second sample queued.
    d_in = 18'h3C0F1; valid = 1'b1;
    cyc(1);
    valid = 1'b0;
    wait_ready(1'b1, "drop_consumed");
    d_in = 18'h21234; valid = 1'b1;
    cyc(1);
    valid = 1'b0;
    cyc(20);
    en = 1'b0;
    cyc(2);
    check("drop_bclk", 64'(bclk), 64'd0);
    check("drop_ws", 64'(ws), 64'd0);
    check("drop_dout", 64'(d_out), 64'd0);
    check("drop_held", 64'(ready), 64'd0);
    cyc(20);
    en = 1'b1;
    cyc(3);
    check("reen_pre_msb", 64'(d_out), 64'd0);
    cyc(1);
    check("reen_msb", 64'(d_out), 64'd1);
    cyc(254);
    check("reen_frame", rx_sr, {18'h21234, 14'b0, 18'h21234, 14'b0});

    // valid arrives on the frame-start edge with an empty holder.
    cyc(1);
    rx_words.delete();
    d_in = 18'h15555; valid = 1'b1;
    cyc(1);
    valid = 1'b0;
    check("simul_und", 64'(underrun), 64'd1);
    check("simul_ready", 64'(ready), 64'd0);
    cyc(326);
    check("simul_nwords", 64'(rx_words.size()), 64'd2);
    if (rx_words.size() == 2) begin
      check("simul_w0", 64'(rx_words[0]), 64'd0);
      check("simul_w1", 64'(rx_words[1]), 64'h15555);
    end

    // Reset mid-frame while enabled.
    cyc(100);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_dout", 64'(d_out), 64'd0);
    check("mrst_ws", 64'(ws), 64'd0);
    check("mrst_bclk", 64'(bclk), 64'd0);
    check("mrst_ready", 64'(ready), 64'd1);
    rr0 = und_cnt;
    cyc(300);
    check("mrst_no_und", 64'(und_cnt), 64'(rr0));
    rst_n = 1'b1;
    cyc(4);
    check("mrst_first_und", 64'(und_cnt), 64'(rr0 + 1));
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/altavoz.md
# altavoz

Serial PCM transmitter for the audio path. It is the playback-side counterpart of the microphone capture block: it accepts 18-bit samples over a valid/ready handshake and serialises each one as an I2S-style stereo frame, duplicating the sample into the left and right slots. It generates its own bit clock (`bclk`) and word select (`ws`) from the system clock, and drives `d_out` toward the DAC/amplifier pins.

## Interface
- `DATA_W`, 18: sample width. Bits are sent MSB first.
- `SLOT_W`, 32: bit clocks per channel slot. Must be greater than `DATA_W`.
- `CLK_DIV`, 8: `clk` cycles per `bclk` half-period. Must be at least 1.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset.
- `enable`  input  1  run/stop control for the serial interface.
- `d_in`  input  `DATA_W`  sample to transmit.
- `valid`  input  1  `d_in` is valid.
- `ready`  output  1  holding register is empty.
- `d_out`  output  1  serial data.
- `ws`  output  1  word select: 0 for the left slot, 1 for the right slot.
- `bclk`  output  1  bit clock.
- `underrun`  output  1  one-`clk` pulse when a frame starts with no sample available.

## Operation
- Divider:
  - While `enable`=1, `bclk` toggles every `CLK_DIV` `clk` cycles, starting from 0.
  - The divider produces internal one-cycle `rise_tk` and `fall_tk` strobes.
  - `d_out` and `ws` change only on `fall_tk` cycles.
- Bit counter `bit_cnt` (6 bits, 0..2·`SLOT_W`−1):
  - Advances on each `fall_tk` and wraps from 63 to 0.
  - Let k = `bit_cnt` mod `SLOT_W`.
- `d_out`:
  - When k < `DATA_W`, drive `frame_reg[DATA_W-1-k]`.
  - Otherwise drive 0.
- `ws`:
  - Set to 1 on the `fall_tk` where `bit_cnt`=31.
  - Cleared to 0 on the `fall_tk` where `bit_cnt`=63.
  - This leads each slot's MSB by one bit (I2S framing).
- Holding register:
  - `ready` is 1 while the holding register is empty.
  - When `valid`=1 and `ready`=1, capture `d_in` and mark the register full.
- Frame start (`fall_tk` with `bit_cnt` advancing to 0):
  - If the holding register is full: `frame_reg` loads the holding value and the holding register becomes empty.
  - If it is empty: `frame_reg` loads 0 and `underrun` pulses. A `valid` in the same cycle is still accepted into the holding register.
  - `frame_reg` is fixed for all 64 bits of the frame.
- `enable`=0:
  - The divider stops and `bclk`, `ws`, `d_out` are forced to 0.
  - `bit_cnt` is set so the next `fall_tk` is a frame start.
  - The holding register and handshake keep working.
  - Deasserting `enable` mid-frame aborts that frame. The aborted sample is discarded, not resent.
- `reset` low:
  - Asynchronously clears all state.
  - The holding register becomes empty.
  - `d_out`, `ws`, `bclk` and `underrun` go to 0 and `ready` goes to 1.

## Timing
- `bclk` period is 2·`CLK_DIV` `clk` cycles.
- After reset release or `enable` rising, the first `rise_tk` comes after `CLK_DIV` cycles and the first `fall_tk` (a frame start) after 2·`CLK_DIV` cycles.
- `d_out` is 0 before the first `fall_tk`.
- `ready` falls on the `clk` edge after an accepted handshake. It rises on the `clk` edge after the frame-start `fall_tk` that consumes the sample.
- Latency: an accepted sample's MSB appears on `d_out` at the next frame-start `fall_tk`. The worst case is one full frame, 128·`CLK_DIV` cycles.
- The receiver samples `d_out` and `ws` on `bclk` rising edges. Data is stable for `CLK_DIV` cycles on either side of each rising edge.
- Throughput is one sample per frame. With `valid` held high, `ready` pulses once per frame.

## Structure
- Shared audio package holds:
  - `DATA_W` = 18 and `SLOT_W` = 32 (common with the capture block).
  - `FRAME_BITS` = 2·`SLOT_W`.
- Sub-module `bclk_gen` contains:
  - The divider counter.
  - The `bclk` register.
  - The `rise_tk`/`fall_tk` strobes.
  - Gating by `enable`.
- The capture block may reuse `bclk_gen`.
- The top level holds the holding register, `frame_reg`, `bit_cnt`, and the `ws`/`d_out` logic.

## Test plan
- Reset: pulse `reset` low mid-frame. Outputs go to 0 immediately, `ready`=1, and there is no `underrun` pulse while reset is held.
- Single sample, `CLK_DIV`=2, `d_in`=18'h2A5A5 accepted before the first frame:
  - Left slot on `d_out` is 10_1010_0101_1010_0101 followed by 14 zeros.
  - Right slot repeats it.
  - `ws` rises 4 `clk` cycles before the right slot's MSB.
- Underrun: `enable`=1 with `valid`=0. `underrun` pulses once per 128·`CLK_DIV` cycles and `d_out` stays 0.
- Streaming: `valid` held high with samples 1, 2, 3. The frames carry 1, 2, 3 in order, `ready` toggles once per frame, and there is no `underrun`.
- Enable drop: deassert `enable` at left-slot bit 5.
  - `bclk`, `ws` and `d_out` go to 0.
  - A sample queued in the holding register is retained.
  - On re-enable, that sample starts at the left-slot MSB 2·`CLK_DIV` cycles later.
- Simultaneous events: `valid` arrives in the frame-start cycle while the holding register is empty. `underrun` pulses, the current frame is zeros, and the sample is sent in the next frame.
